// File: rtl/maze_solver.sv
// Depth-first maze solver over a 16x16 open/wall bitmap; publishes the live DFS path and cursor.
// Optional step-budget abort and timeout port when MAZE_SOLVER_TIMEOUT_EN is defined.
module maze_solver #(
  parameter int STACK_DEPTH = 256,
  parameter int MAX_STEPS   = 1023
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         step_en,
  input  logic [255:0] maze_data,
  input  logic [4:0]   maze_width,
  input  logic [4:0]   maze_height,
  input  logic [3:0]   start_x,
  input  logic [3:0]   start_y,
  input  logic [3:0]   goal_x,
  input  logic [3:0]   goal_y,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic [3:0]   curr_x,
  output logic [3:0]   curr_y,
  output logic [255:0] path_data,
`ifdef MAZE_SOLVER_TIMEOUT_EN
  output logic         timeout,
`endif
  output logic [8:0]   path_len
);

  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t         state_q, state_d;
  logic [3:0]     curr_x_q, curr_x_d, curr_y_q, curr_y_d;
  logic [255:0]   visited_q, visited_d, path_q, path_d;
  logic [8:0]     len_q, len_d;
  logic [AW-1:0]  sp_q, sp_d;
  logic           found_q, found_d;
  logic           push_en;
  logic [7:0]     stack_q [STACK_DEPTH];

`ifdef MAZE_SOLVER_TIMEOUT_EN
  logic [9:0]     step_cnt_q, step_cnt_d;
  logic           timeout_q, timeout_d;
`endif

  logic [4:0]     w_eff, h_eff;
  logic [7:0]     cur_idx, start_idx, nbr_idx, top_idx;
  logic [7:0]     up_idx, lf_idx, dn_idx, rt_idx;
  logic           up_ok, lf_ok, dn_ok, rt_ok;
  logic           nbr_ok, at_goal, start_bad, stack_full;
  logic [3:0]     nbr_x, nbr_y;

  assign w_eff     = (maze_width  > 5'd16) ? 5'd16 : maze_width;
  assign h_eff     = (maze_height > 5'd16) ? 5'd16 : maze_height;
  assign cur_idx   = {curr_y_q, curr_x_q};
  assign start_idx = {start_y, start_x};
  assign at_goal   = (curr_x_q == goal_x) && (curr_y_q == goal_y);
  assign stack_full = (sp_q == AW'(STACK_DEPTH - 1));
  assign top_idx   = stack_q[sp_q - 1'b1];

  assign start_bad = (w_eff == 5'd0) || (h_eff == 5'd0) ||
                     ({1'b0, start_x} >= w_eff) || ({1'b0, start_y} >= h_eff) ||
                     !maze_data[start_idx];

  // Index arithmetic may wrap in 4 bits; the bound terms gate any wrapped index.
  assign up_idx = {curr_y_q - 4'd1, curr_x_q};
  assign lf_idx = {curr_y_q, curr_x_q - 4'd1};
  assign dn_idx = {curr_y_q + 4'd1, curr_x_q};
  assign rt_idx = {curr_y_q, curr_x_q + 4'd1};

  assign up_ok = (curr_y_q != 4'd0) && maze_data[up_idx] && !visited_q[up_idx];
  assign lf_ok = (curr_x_q != 4'd0) && maze_data[lf_idx] && !visited_q[lf_idx];
  assign dn_ok = (({1'b0, curr_y_q} + 5'd1) < h_eff) && maze_data[dn_idx] && !visited_q[dn_idx];
  assign rt_ok = (({1'b0, curr_x_q} + 5'd1) < w_eff) && maze_data[rt_idx] && !visited_q[rt_idx];

  always_comb begin
    nbr_ok = 1'b1;
    nbr_x  = curr_x_q;
    nbr_y  = curr_y_q;
    if (up_ok) begin
      nbr_y = curr_y_q - 4'd1;
    end else if (lf_ok) begin
      nbr_x = curr_x_q - 4'd1;
    end else if (dn_ok) begin
      nbr_y = curr_y_q + 4'd1;
    end else if (rt_ok) begin
      nbr_x = curr_x_q + 4'd1;
    end else begin
      nbr_ok = 1'b0;
    end
  end

  assign nbr_idx = {nbr_y, nbr_x};

  always_comb begin
    state_d   = state_q;
    curr_x_d  = curr_x_q;
    curr_y_d  = curr_y_q;
    visited_d = visited_q;
    path_d    = path_q;
    len_d     = len_q;
    sp_d      = sp_q;
    found_d   = found_q;
    push_en   = 1'b0;
`ifdef MAZE_SOLVER_TIMEOUT_EN
    step_cnt_d = step_cnt_q;
    timeout_d  = timeout_q;
`endif
    if (start) begin
      curr_x_d  = start_x;
      curr_y_d  = start_y;
      sp_d      = '0;
      found_d   = 1'b0;
      visited_d = '0;
      path_d    = '0;
`ifdef MAZE_SOLVER_TIMEOUT_EN
      step_cnt_d = '0;
      timeout_d  = 1'b0;
`endif
      if (start_bad) begin
        state_d = DONE;
        len_d   = 9'd0;
      end else begin
        state_d              = SEARCH;
        visited_d[start_idx] = 1'b1;
        path_d[start_idx]    = 1'b1;
        len_d                = 9'd1;
      end
    end else if ((state_q == SEARCH) && step_en) begin
      if (at_goal) begin
        state_d = DONE;
        found_d = 1'b1;
      end else if (nbr_ok && !stack_full) begin
        push_en            = 1'b1;
        sp_d               = sp_q + 1'b1;
        curr_x_d           = nbr_x;
        curr_y_d           = nbr_y;
        visited_d[nbr_idx] = 1'b1;
        path_d[nbr_idx]    = 1'b1;
        len_d              = len_q + 9'd1;
      end else if (sp_q == '0) begin
        state_d = DONE;
      end else begin
        path_d[cur_idx] = 1'b0;
        curr_x_d        = top_idx[3:0];
        curr_y_d        = top_idx[7:4];
        sp_d            = sp_q - 1'b1;
        len_d           = len_q - 9'd1;
      end
`ifdef MAZE_SOLVER_TIMEOUT_EN
      step_cnt_d = step_cnt_q + 10'd1;
      if ((state_d == SEARCH) && ((int'(step_cnt_q) + 1) >= MAX_STEPS)) begin
        state_d   = DONE;
        timeout_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      curr_x_q  <= '0;
      curr_y_q  <= '0;
      visited_q <= '0;
      path_q    <= '0;
      len_q     <= '0;
      sp_q      <= '0;
      found_q   <= 1'b0;
`ifdef MAZE_SOLVER_TIMEOUT_EN
      step_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      curr_x_q  <= curr_x_d;
      curr_y_q  <= curr_y_d;
      visited_q <= visited_d;
      path_q    <= path_d;
      len_q     <= len_d;
      sp_q      <= sp_d;
      found_q   <= found_d;
`ifdef MAZE_SOLVER_TIMEOUT_EN
      step_cnt_q <= step_cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  // Stack storage needs no reset: only entries below sp are ever read.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_q[sp_q] <= cur_idx;
    end
  end

  assign busy      = (state_q == SEARCH);
  assign done      = (state_q == DONE);
  assign found     = found_q;
  assign curr_x    = curr_x_q;
  assign curr_y    = curr_y_q;
  assign path_data = path_q;
  assign path_len  = len_q;
`ifdef MAZE_SOLVER_TIMEOUT_EN
  assign timeout   = timeout_q;
`endif

endmodule

// File: tb/tb_maze_solver.sv
// Bench for maze_solver: directed vector table, hand sequences, and randomized mazes vs a DFS model.
module tb_maze_solver;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         step_en;
  logic [255:0] maze_data;
  logic [4:0]   maze_width, maze_height;
  logic [3:0]   start_x, start_y, goal_x, goal_y;
  logic         busy, done, found;
  logic [3:0]   curr_x, curr_y;
  logic [255:0] path_data;
  logic [8:0]   path_len;

  always #5 clk = ~clk;

`ifdef MAZE_SOLVER_TIMEOUT_EN
  logic         timeout;
  logic         t_busy, t_done, t_found, t_timeout;
  logic [3:0]   t_curr_x, t_curr_y;
  logic [255:0] t_path_data;
  logic [8:0]   t_path_len;
`endif

  maze_solver dut (
    .clk(clk), .rst_n(rst_n), .start(start), .step_en(step_en),
    .maze_data(maze_data), .maze_width(maze_width), .maze_height(maze_height),
    .start_x(start_x), .start_y(start_y), .goal_x(goal_x), .goal_y(goal_y),
    .busy(busy), .done(done), .found(found), .curr_x(curr_x), .curr_y(curr_y),
    .path_data(path_data),
`ifdef MAZE_SOLVER_TIMEOUT_EN
    .timeout(timeout),
`endif
    .path_len(path_len)
  );

`ifdef MAZE_SOLVER_TIMEOUT_EN
  maze_solver #(.MAX_STEPS(3)) dut_to (
    .clk(clk), .rst_n(rst_n), .start(start), .step_en(step_en),
    .maze_data(maze_data), .maze_width(maze_width), .maze_height(maze_height),
    .start_x(start_x), .start_y(start_y), .goal_x(goal_x), .goal_y(goal_y),
    .busy(t_busy), .done(t_done), .found(t_found), .curr_x(t_curr_x), .curr_y(t_curr_y),
    .path_data(t_path_data), .timeout(t_timeout), .path_len(t_path_len)
  );
`endif

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] bm(input int a, input int b, input int c, input int d);
    logic [255:0] v;
    v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    if (c >= 0) v[c] = 1'b1;
    if (d >= 0) v[d] = 1'b1;
    return v;
  endfunction

  task automatic set_case(input logic [255:0] m, input logic [4:0] w, input logic [4:0] h,
                          input logic [3:0] sx, input logic [3:0] sy,
                          input logic [3:0] gx, input logic [3:0] gy);
    maze_data = m; maze_width = w; maze_height = h;
    start_x = sx; start_y = sy; goal_x = gx; goal_y = gy;
  endtask

  // Pulse start with step_en high, then count edges until done (bounded).
  task automatic run_search(output int steps, output int max_x, output bit hung);
    start = 1'b1; step_en = 1'b1;
    tick();
    start = 1'b0;
    steps = 0;
    max_x = int'(curr_x);
    while (!done && steps < 2000) begin
      tick();
      steps++;
      if (int'(curr_x) > max_x) max_x = int'(curr_x);
    end
    hung = !done;
  endtask

  typedef struct {
    string        name;
    logic [255:0] maze;
    logic [4:0]   w, h;
    logic [3:0]   sx, sy, gx, gy;
    bit           exp_found;
    int           exp_steps;
    int           exp_max_x;
    bit           chk_path;
    int           exp_len;
    logic [255:0] exp_path;
  } vec_t;

  vec_t vecs[7];

  // Reference model: DFS expressed on cell coordinates with a queue as the backtrack stack.
  bit m_vis[256];
  bit m_path[256];
  int m_stk[$];
  int m_cx, m_cy, m_len, m_w, m_h;
  bit m_busy, m_done, m_found, m_degen;

  task automatic m_start();
    int s;
    m_w = (maze_width  > 16) ? 16 : int'(maze_width);
    m_h = (maze_height > 16) ? 16 : int'(maze_height);
    s = int'(start_x) + 16 * int'(start_y);
    m_cx = int'(start_x); m_cy = int'(start_y);
    m_stk.delete();
    for (int i = 0; i < 256; i++) begin m_vis[i] = 0; m_path[i] = 0; end
    m_found = 0;
    if (m_w == 0 || m_h == 0 || m_cx >= m_w || m_cy >= m_h || !maze_data[s]) begin
      m_degen = 1; m_busy = 0; m_done = 1; m_len = 0;
    end else begin
      m_degen = 0; m_busy = 1; m_done = 0; m_len = 1;
      m_vis[s] = 1; m_path[s] = 1;
    end
  endtask

  task automatic m_step();
    int dxs[4] = '{0, -1, 0, 1};
    int dys[4] = '{-1, 0, 1, 0};
    int nx, ny, c;
    bit moved;
    moved = 0;
    if (m_cx == int'(goal_x) && m_cy == int'(goal_y)) begin
      m_done = 1; m_found = 1; m_busy = 0;
      return;
    end
    for (int d = 0; d < 4 && !moved; d++) begin
      nx = m_cx + dxs[d];
      ny = m_cy + dys[d];
      if (nx >= 0 && nx < m_w && ny >= 0 && ny < m_h && m_stk.size() < 255) begin
        if (maze_data[nx + 16 * ny] && !m_vis[nx + 16 * ny]) begin
          m_stk.push_back(m_cx + 16 * m_cy);
          m_cx = nx; m_cy = ny;
          m_vis[nx + 16 * ny] = 1; m_path[nx + 16 * ny] = 1;
          m_len++;
          moved = 1;
        end
      end
    end
    if (moved) return;
    if (m_stk.size() == 0) begin
      m_done = 1; m_busy = 0;
    end else begin
      m_path[m_cx + 16 * m_cy] = 0;
      c = m_stk.pop_back();
      m_cx = c % 16; m_cy = c / 16;
      m_len--;
    end
  endtask

  function automatic logic [255:0] m_path_bits();
    logic [255:0] v;
    for (int i = 0; i < 256; i++) v[i] = m_path[i];
    return v;
  endfunction

  initial begin
    int steps, max_x, err0, cyc;
    bit hung, en;
    logic [255:0] corridor;

    corridor = bm(0, 1, 2, 3);
    rst_n = 1'b0; start = 1'b0; step_en = 1'b0;
    set_case('0, 5'd16, 5'd16, 4'd0, 4'd0, 4'd0, 4'd0);

    vecs[0] = '{"corridor",   corridor,           5'd16, 5'd16, 4'd0,  4'd0, 4'd3, 4'd0, 1'b1, 4, 3,  1'b1, 4, corridor};
    vecs[1] = '{"backtrack",  bm(0, 16, 1, 2),    5'd16, 5'd16, 4'd0,  4'd0, 4'd2, 4'd0, 1'b1, 5, 2,  1'b1, 3, bm(0, 1, 2, -1)};
    vecs[2] = '{"unreach",    bm(0, 1, 16, 17),   5'd16, 5'd16, 4'd0,  4'd0, 4'd5, 4'd5, 1'b0, 7, 1,  1'b1, 1, bm(0, -1, -1, -1)};
    vecs[2].maze[85] = 1'b1;
    vecs[3] = '{"bounds",     bm(0, 1, 2, -1),    5'd2,  5'd16, 4'd0,  4'd0, 4'd2, 4'd0, 1'b0, 3, 1,  1'b1, 1, bm(0, -1, -1, -1)};
    vecs[4] = '{"wall_start", bm(1, 2, -1, -1),   5'd16, 5'd16, 4'd0,  4'd0, 4'd2, 4'd0, 1'b0, 0, 0,  1'b0, 0, '0};
    vecs[5] = '{"zero_width", bm(0, 1, -1, -1),   5'd0,  5'd16, 4'd0,  4'd0, 4'd1, 4'd0, 1'b0, 0, 0,  1'b0, 0, '0};
    vecs[6] = '{"clamp_w",    bm(15, 0, -1, -1),  5'd20, 5'd16, 4'd15, 4'd0, 4'd0, 4'd0, 1'b0, 1, 15, 1'b1, 1, bm(15, -1, -1, -1)};

    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_found", found, 0);
    chk("rst_curr", {curr_y, curr_x}, 0);
    chk("rst_path", path_data, 0);
    chk("rst_len", path_len, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      set_case(vecs[v].maze, vecs[v].w, vecs[v].h, vecs[v].sx, vecs[v].sy, vecs[v].gx, vecs[v].gy);
      run_search(steps, max_x, hung);
      chk({vecs[v].name, "_done"}, done, 1);
      chk({vecs[v].name, "_busy"}, busy, 0);
      chk({vecs[v].name, "_found"}, found, vecs[v].exp_found);
      chk({vecs[v].name, "_steps"}, steps, vecs[v].exp_steps);
      chk({vecs[v].name, "_max_x"}, max_x, vecs[v].exp_max_x);
      if (vecs[v].chk_path) begin
        chk({vecs[v].name, "_len"}, path_len, vecs[v].exp_len);
        chk({vecs[v].name, "_path"}, path_data, vecs[v].exp_path);
      end
    end

    // DONE holds while step_en toggles
    for (int i = 0; i < 10; i++) begin step_en = i[0]; tick(); end
    chk("hold_done", done, 1);
    chk("hold_curr_x", curr_x, 15);

    // step_en gating, then restart mid-search with a simultaneous step
    set_case(corridor, 5'd16, 5'd16, 4'd0, 4'd0, 4'd3, 4'd0);
    start = 1'b1; step_en = 1'b0;
    tick();
    start = 1'b0;
    repeat (50) tick();
    chk("gate_curr", {curr_y, curr_x}, 0);
    chk("gate_busy", busy, 1);
    chk("gate_len", path_len, 1);
    step_en = 1'b1;
    tick();
    step_en = 1'b0;
    chk("gate_step_x", curr_x, 1);
    chk("gate_step_len", path_len, 2);
    start = 1'b1; step_en = 1'b1;
    tick();
    start = 1'b0; step_en = 1'b0;
    chk("restart_len", path_len, 1);
    chk("restart_done", done, 0);
    chk("restart_curr", {curr_y, curr_x}, 0);
    chk("restart_path", path_data, bm(0, -1, -1, -1));

    // async reset mid-search
    step_en = 1'b1;
    tick(); tick();
    chk("pre_rst_x", curr_x, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_curr", {curr_y, curr_x}, 0);
    chk("arst_path", path_data, 0);
    chk("arst_len", path_len, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step_en = 1'b0;

`ifdef MAZE_SOLVER_TIMEOUT_EN
    set_case(corridor, 5'd16, 5'd16, 4'd0, 4'd0, 4'd3, 4'd0);
    start = 1'b1; step_en = 1'b1;
    tick();
    start = 1'b0;
    steps = 0;
    while (!t_done && steps < 20) begin tick(); steps++; end
    chk("to_done", t_done, 1);
    chk("to_found", t_found, 0);
    chk("to_timeout", t_timeout, 1);
    chk("to_steps", steps, 3);
    tick();
    chk("main_no_timeout", timeout, 0);
    chk("main_found", found, 1);
`endif

    for (int r = 0; r < 25; r++) begin
      logic [255:0] m;
      for (int i = 0; i < 8; i++) m[i*32 +: 32] = $urandom | $urandom;
      set_case(m, ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 20)) : 5'd16,
               ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 20)) : 5'd16,
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 4) != 0) maze_data[{start_y, start_x}] = 1'b1;
      err0 = errors;
      start = 1'b1; step_en = 1'($urandom_range(0, 1));
      tick();
      start = 1'b0;
      m_start();
      cyc = 0;
      while (cyc < 3000 && errors == err0) begin
        chk("rnd_busy", busy, m_busy);
        chk("rnd_done", done, m_done);
        chk("rnd_found", found, m_found);
        if (!m_degen) begin
          chk("rnd_curr", {curr_y, curr_x}, {4'(m_cy), 4'(m_cx)});
          chk("rnd_len", path_len, m_len);
        end
        if (m_done) break;
        en = 1'($urandom_range(0, 1));
        step_en = en;
        tick();
        if (en && m_busy) m_step();
        cyc++;
      end
      chk("rnd_finished", m_done, 1);
      if (!m_degen) chk("rnd_path", path_data, m_path_bits());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/maze_solver.md
Name: maze_solver

Overview:
- Reader-side counterpart to the maze carver. Consumes the carved 16x16 maze bitmap (bit index x + 16*y; 1 = open, 0 = wall).
- Runs a depth-first search from a start cell to a goal cell, normally the carver's finish_x/finish_y.
- Publishes the solution path as a bitmap overlay for the VGA/display logic, plus a live cursor for animation.
- One search move per enabled step, paced by step_en from the top-level slow-tick counter.

Parameters:
- STACK_DEPTH, 256, entries in the backtrack stack (one per cell of a 16x16 maze).
- MAX_STEPS, 1023, step budget before abort; used only when MAZE_SOLVER_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin or restart a search; level, sampled each clk
- step_en  in  1  one-cycle tick; permits one search step
- maze_data  in  256  maze bitmap; must be held stable while busy
- maze_width  in  5  usable columns (1..16)
- maze_height  in  5  usable rows (1..16)
- start_x, start_y  in  4 each  start cell
- goal_x, goal_y  in  4 each  goal cell
- busy  out  1  search in progress
- done  out  1  search finished; held until next start
- found  out  1  valid with done; 1 = goal reached
- curr_x, curr_y  out  4 each  current search cursor
- path_data  out  256  1 = cell is on the current DFS path
- path_len  out  9  cells on the path, start included

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, found=0.
  - curr_x=0, curr_y=0, path_data=0, path_len=0.
  - Stack pointer and visited map cleared.
- States:
  - IDLE, SEARCH, DONE.
  - start=1 in any state: on the next edge go to SEARCH.
  - On entering SEARCH: visited=0 except start cell; path_data=only start bit; curr=start; sp=0; path_len=1; busy=1; done=0; found=0.
  - start has priority over a simultaneous step. Holding start high keeps re-initialising.
- Degenerate start: if the start cell is a wall, out of bounds, or width or height is 0, enter DONE with found=0. No steps are taken.
- Width/height clamp: values above 16 are treated as 16.
- SEARCH step (only on clk with step_en=1), evaluated in this order:
  1. curr==goal: done=1, found=1, busy=0, go to DONE. Path is left intact.
  2. Else probe neighbours in fixed priority up, left, down, right. A neighbour is eligible if:
     - it is in bounds (0<=x<width, 0<=y<height, no 4-bit wrap);
     - maze_data bit = 1;
     - it is not visited.
     First eligible neighbour: push curr, move there, set its visited and path bits, path_len+1.
  3. Else if sp==0: done=1, found=0, busy=0, go to DONE.
  4. Else pop: clear the path bit of curr, curr=stack[sp-1], sp-1, path_len-1.
- Latency: with step_en tied high, exactly one move, pop or goal check per clk. Goal detection costs one step after arriving on the goal.
- Stack full (sp==STACK_DEPTH-1) with an eligible neighbour: treated as stuck, so the step pops. This cannot occur on a legal 16x16 maze.
- DONE: outputs hold; step_en is ignored; only start or reset leaves.
- maze_data changing mid-search: result undefined. The bench must not do this.

Optional Feature:
- Macro: MAZE_SOLVER_TIMEOUT_EN.
- When defined:
  - An internal 10-bit step counter clears on start and increments on each SEARCH step.
  - When it reaches MAX_STEPS with no result, enter DONE with found=0.
  - Output port timeout (1 bit) = 1, held until the next start; reset value 0.
- When undefined: no counter, no timeout port; search runs until found or stack empty.

Test Plan:
- Corridor: open cells (0,0)..(3,0), start (0,0), goal (3,0), 16x16, step_en=1. Start pulse at edge k:
  - done=1, found=1 after edge k+4;
  - path_len=4, path_data bits 0..3 set, all others 0.
- Backtrack: open (0,0),(0,1),(1,0),(2,0), goal (2,0):
  - 5 steps: down, pop, right, right, detect;
  - found=1, path_len=3, bits 0,1,2 set, bit 16 clear.
- Unreachable: goal (5,5) walled off:
  - done=1, found=0, path_len=1 (start only), path_data=bit of start only.
- Bounds: width=2, open (0,0),(1,0),(2,0), goal (2,0) → found=0; never steps past x=1.
- step_en gating/restart:
  - step_en low for 50 clks → curr unchanged, busy=1.
  - Asserting start mid-search re-initialises: path_len=1, done=0.
  - rst_n low mid-search clears all outputs asynchronously.
- Timeout (macro on, MAX_STEPS=3) on the corridor with goal (3,0) → done=1, found=0, timeout=1.
